// File: rtl/pipelined_rca_pkg.sv
// Shared constants for the pipelined ripple-carry adder.
// Default geometry and the stage-count helper.
package pipelined_rca_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    function automatic int num_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational N-bit ripple adder built from full-adder cells.
// Exposes the carry into its MSB for signed-overflow detection.
module rca_chunk
    import pipelined_rca_pkg::*;
#(
    parameter int N = DEF_CHUNK
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co,
    output logic         cmsb
);

    logic c;

    always_comb begin
        c    = ci;
        cmsb = ci;
        s    = '0;
        for (int i = 0; i < N; i++) begin
            cmsb = c;
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/pipelined_rca.sv
// Pipelined add/subtract: one CHUNK-bit ripple slice per stage,
// operands skewed forward and sum chunks deskewed through the stages.
module pipelined_rca
    import pipelined_rca_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int STAGES = num_stages(WIDTH, CHUNK);

    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad
        $error("pipelined_rca: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    logic             advance;
    logic [WIDTH-1:0] beff;
    logic             c0;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign beff     = b ^ {WIDTH{sub}};
    assign c0       = sub ? 1'b1 : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO = k * CHUNK;
        localparam int RW = WIDTH - LO - CHUNK;

        logic [RW+CHUNK-1:0] ua;
        logic [RW+CHUNK-1:0] ub;
        logic [CHUNK-1:0]    cs;
        logic [LO+CHUNK-1:0] ns;
        logic [LO+CHUNK-1:0] rs;
        logic                ci, co, cm, pv;
        logic                v, c;

        // Stage 0 sees raw operands; later stages see the skewed remainder
        if (k == 0) begin : g_src
            assign ua = a;
            assign ub = beff;
            assign ci = c0;
            assign pv = in_valid;
            assign ns = cs;
        end else begin : g_src
            assign ua = g_stg[k-1].g_up.ra;
            assign ub = g_stg[k-1].g_up.rb;
            assign ci = g_stg[k-1].c;
            assign pv = g_stg[k-1].v;
            assign ns = {cs, g_stg[k-1].rs};
        end

        rca_chunk #(.N(CHUNK)) u_chunk (
            .a    (ua[CHUNK-1:0]),
            .b    (ub[CHUNK-1:0]),
            .ci   (ci),
            .s    (cs),
            .co   (co),
            .cmsb (cm)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v  <= 1'b0;
                c  <= 1'b0;
                rs <= '0;
            end else if (advance) begin
                v  <= pv;
                c  <= co;
                rs <= ns;
            end
        end

        if (RW > 0) begin : g_up
            logic [RW-1:0] ra;
            logic [RW-1:0] rb;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ra <= '0;
                    rb <= '0;
                end else if (advance) begin
                    ra <= ua[RW+CHUNK-1:CHUNK];
                    rb <= ub[RW+CHUNK-1:CHUNK];
                end
            end
        end

        if (k == STAGES - 1) begin : g_last
            logic m;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    m <= 1'b0;
                end else if (advance) begin
                    m <= cm;
                end
            end
        end else begin : g_mid
            logic unused_cm;
            assign unused_cm = cm;
        end
    end

    assign out_valid = g_stg[STAGES-1].v;
    assign sum       = g_stg[STAGES-1].rs;
    assign cout      = g_stg[STAGES-1].c;
    assign ovf       = g_stg[STAGES-1].g_last.m ^ g_stg[STAGES-1].c;

endmodule

// File: tb/tb_pipelined_rca.sv
// Self-checking bench for pipelined_rca (WIDTH=16, CHUNK=4).
// Arithmetic reference model with an in-order expectation queue.
module tb_pipelined_rca;

    localparam int W = 16;
    localparam int LAT = 3;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a, b;
    logic         cin, sub, in_valid, out_ready;
    logic         in_ready, cout, ovf, out_valid;
    logic [W-1:0] sum;

    pipelined_rca #(.WIDTH(W), .CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           acc;
    } exp_t;

    exp_t         q[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           popcnt = 0;
    bit           lat_chk = 0;
    bit           hold = 0;
    logic [W-1:0] h_sum;
    logic         h_cout, h_ovf;
    bit           seen = 0;
    logic [W-1:0] seen_sum;
    logic         seen_cout, seen_ovf;

    function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y,
                                   logic ci, logic sb);
        exp_t        e;
        logic [W:0]  full;
        logic [W-1:0] ny;
        ny = ~y;
        if (sb) full = {1'b0, x} + {1'b0, ny} + (W+1)'(1);
        else    full = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
        e.s = full[W-1:0];
        e.c = full[W];
        if (sb) e.o = (x[W-1] != y[W-1]) && (e.s[W-1] != x[W-1]);
        else    e.o = (x[W-1] == y[W-1]) && (e.s[W-1] != x[W-1]);
        e.acc = 0;
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(output bit acc);
        exp_t e;
        @(negedge clk);
        acc = 0;
        if (rst_n) chk("in_ready", in_ready, !out_valid || out_ready);
        if (hold) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_sum", sum, h_sum);
            chk("hold_cout", cout, h_cout);
            chk("hold_ovf", ovf, h_ovf);
        end
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_out_valid", out_valid, 1'b0);
            end else if (out_ready) begin
                e = q.pop_front();
                popcnt++;
                chk("sum", sum, e.s);
                chk("cout", cout, e.c);
                chk("ovf", ovf, e.o);
                if (lat_chk) chk("latency", cyc - e.acc, LAT);
                seen      = 1;
                seen_sum  = sum;
                seen_cout = cout;
                seen_ovf  = ovf;
            end
        end
        hold   = rst_n && out_valid && !out_ready;
        h_sum  = sum;
        h_cout = cout;
        h_ovf  = ovf;
        if (rst_n && in_valid && in_ready) begin
            e = model(a, b, cin, sub);
            e.acc = cyc + 1;
            q.push_back(e);
            acc = 1;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic single(logic [W-1:0] ta, logic [W-1:0] tb2, logic tc,
                          logic ts, logic [W-1:0] es, logic ec, logic eo);
        bit acc;
        a = ta; b = tb2; cin = tc; sub = ts;
        in_valid = 1; out_ready = 1;
        seen = 0;
        tick(acc);
        in_valid = 0;
        a = $urandom; b = $urandom; cin = $urandom; sub = $urandom;
        for (int i = 0; i < 10 && !seen; i++) tick(acc);
        chk("single_seen", seen, 1'b1);
        chk("single_sum", seen_sum, es);
        chk("single_cout", seen_cout, ec);
        chk("single_ovf", seen_ovf, eo);
        tick(acc);
    endtask

    initial begin
        bit           acc;
        int           idx;
        int           p0;
        logic [W-1:0] va[8];
        logic [W-1:0] vb[8];

        rst_n = 0; a = 0; b = 0; cin = 0; sub = 0;
        in_valid = 0; out_ready = 1;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_sum", sum, 16'h0);
        chk("rst_cout", cout, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        tick(acc);
        tick(acc);
        rst_n = 1;

        lat_chk = 1;
        single(16'h0002, 16'h0001, 0, 0, 16'h0003, 0, 0);
        single(16'hFFFF, 16'h0001, 1, 0, 16'h0001, 1, 0);
        single(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);
        single(16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0);
        single(16'h8000, 16'h0001, 1, 1, 16'h7FFF, 1, 1);

        lat_chk = 0;
        for (int i = 0; i < 8; i++) begin
            va[i] = $urandom;
            vb[i] = $urandom;
        end
        idx = 0;
        p0 = popcnt;
        for (int i = 0; i < 24; i++) begin
            out_ready = !(i >= 5 && i <= 9);
            in_valid  = idx < 8;
            if (idx < 8) begin
                a = va[idx]; b = vb[idx];
                cin = idx[0]; sub = idx[1];
            end
            tick(acc);
            if (acc) idx++;
        end
        chk("stall_count", popcnt - p0, 8);

        for (int i = 0; i < 300; i++) begin
            a = $urandom; b = $urandom;
            cin = $urandom; sub = $urandom;
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            tick(acc);
        end
        in_valid = 0; out_ready = 1;
        for (int i = 0; i < 10 && q.size() != 0; i++) tick(acc);
        chk("drain_empty", q.size(), 0);

        lat_chk = 1;
        for (int i = 0; i < 3; i++) begin
            a = $urandom; b = $urandom; cin = 0; sub = 0;
            in_valid = 1;
            tick(acc);
        end
        in_valid = 0;
        tick(acc);
        #2;
        rst_n = 0;
        #1;
        chk("async_out_valid", out_valid, 1'b0);
        chk("async_sum", sum, 16'h0);
        q.delete();
        hold = 0;
        tick(acc);
        rst_n = 1;
        for (int i = 0; i < 6; i++) tick(acc);
        single(16'h1234, 16'h1111, 0, 0, 16'h2345, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_rca.md
PIPELINED_RCA -- requirements
Module: pipelined_rca

Interface
REQ-001 Parameter WIDTH, default 16, operand/sum width in bits, SHALL be >= 2.
REQ-002 Parameter CHUNK, default 4, bits resolved per pipeline stage; WIDTH % CHUNK SHALL equal 0; STAGES = WIDTH/CHUNK.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 a  input  WIDTH  operand A, unsigned/two's complement.
REQ-006 b  input  WIDTH  operand B.
REQ-007 cin  input  1  carry-in, used when sub=0.
REQ-008 sub  input  1  mode: 0 = a+b+cin, 1 = a-b (a + ~b + 1; cin ignored).
REQ-009 in_valid  input  1  operands present this cycle.
REQ-010 in_ready  output  1  block accepts operands this cycle.
REQ-011 sum  output  WIDTH  result.
REQ-012 cout  output  1  carry out of MSB (sub=1: 1 = no borrow).
REQ-013 ovf  output  1  signed overflow.
REQ-014 out_valid  output  1  sum/cout/ovf valid.
REQ-015 out_ready  input  1  downstream accepts result.

Function
REQ-016 Stage k (0..STAGES-1) SHALL add bits [k*CHUNK +: CHUNK] using the carry registered by stage k-1 (stage 0: cin or 1 per sub).
REQ-017 Unprocessed upper operand chunks and completed lower sum chunks SHALL travel with their transaction through stage registers (skew/deskew).
REQ-018 Transfer in: in_valid && in_ready; transfer out: out_valid && out_ready.
REQ-019 advance = !out_valid || out_ready; in_ready SHALL equal advance (combinational, no dependency on in_valid).
REQ-020 When advance=1 every stage register and per-stage valid bit SHALL shift one stage; when 0 all SHALL hold.
REQ-021 Latency: accepted input at edge N SHALL appear on outputs after edge N+STAGES-1 if never stalled (out_valid high in cycle after edge N+STAGES-1); throughput one result/cycle.
REQ-022 Bubbles (in_valid=0 while advancing) SHALL propagate as valid=0 stages; no bubble collapsing.
REQ-023 Outputs SHALL be driven directly from the last stage registers; stable while out_valid && !out_ready.
REQ-024 cout SHALL be carry out of bit WIDTH-1; ovf SHALL be carry into bit WIDTH-1 XOR cout.
REQ-025 Results SHALL be modulo 2^WIDTH; sub and effective b SHALL be latched at acceptance, not sampled later.
REQ-026 CHUNK == WIDTH SHALL yield single-stage latency of 1 with identical handshake.

Reset
REQ-027 rst_n low SHALL asynchronously clear all valid bits, carries, data registers; sum=0, cout=0, ovf=0, out_valid=0.
REQ-028 Reset mid-operation SHALL discard all in-flight transactions; first acceptance possible on first edge after rst_n deasserts (in_ready=1 since out_valid=0).

Structure
REQ-029 One combinational sub-module rca_chunk (CHUNK-bit ripple adder of full-adder cells, carry in/out, carry into MSB exposed) SHALL be instantiated STAGES times via generate.
REQ-030 A shared package pipelined_rca_pkg SHALL hold default WIDTH/CHUNK constants and a function computing STAGES; no typedefs needed.
REQ-031 Elaboration SHALL fail on WIDTH % CHUNK != 0.

Verification (WIDTH=16, CHUNK=4, STAGES=4)
REQ-032 Reset then a=0x0002, b=0x0001, cin=0, sub=0, one beat, out_ready=1 -> out_valid one cycle, 4 edges later, sum=0x0003, cout=0, ovf=0.
REQ-033 a=0xFFFF, b=0x0001, cin=1 -> sum=0x0001, cout=1, ovf=0; a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, ovf=1, cout=0.
REQ-034 sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0; a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1, cout=1.
REQ-035 Back-to-back 8 beats with out_ready=0 from cycle 5 to 9 -> in_ready low during stall, outputs held, no loss/duplication, order preserved versus reference model.
REQ-036 rst_n asserted with 3 transactions in flight -> out_valid=0 immediately, none emerge after release; fresh beat 0x1234+0x1111 -> 0x2345.
